// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the parametrised floating-point square-root unit.
// Provides the controller state encoding, operand class encoding, the exponent
// bias helper and the canonical quiet-NaN bit pattern.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    NORM,
    ZERO,
    INF,
    NAN,
    NEG
  } cls_e;

  // Widest {exp, frac} pattern qnan() can describe; callers slice what they need.
  localparam int QNAN_MAX_W = 128;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN packed as {exp, frac} in the low bits: exponent all ones,
  // fraction MSB set, everything else zero (sign bit is left to the caller).
  function automatic logic [QNAN_MAX_W-1:0] qnan(input int exp_w, input int frac_w);
    logic [QNAN_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[frac_w + i] = 1'b1;
    end
    v[frac_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_sqrt_core.sv
// Restoring square-root recurrence: one root bit per cycle over N cycles.
// Latency N cycles after start_i; start_i is only issued while the core is idle.
// Ports: clk, rst_ni (async active-low), start_i/rad_i load a 2N-bit integer
//   radicand; done_o is high during the cycle whose closing edge performs the
//   final iteration; root_o = floor(sqrt(rad)), sticky_o = remainder nonzero.
module fp_sqrt_core #(
  parameter int N = 54
) (
  input  logic           clk,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [2*N-1:0] rad_i,
  output logic           done_o,
  output logic [N-1:0]   root_o,
  output logic           sticky_o
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] rad_q;
  logic [N:0]     rem_q;
  logic [N-1:0]   root_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  // The partial remainder never exceeds twice the partial root, so N+1 bits
  // hold it; the trial subtraction needs two extra bits of headroom.
  logic [N+2:0] acc;
  logic [N+2:0] trial;
  logic [N+2:0] rem_nxt;
  logic         ge;
  logic         unused_rem_bits;

  always_comb begin
    acc     = {rem_q, rad_q[2*N-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    ge      = (acc >= trial);
    rem_nxt = ge ? (acc - trial) : acc;
  end

  assign unused_rem_bits = ^rem_nxt[N+2:N+1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rad_q  <= rad_i;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CW'(N);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q  <= {rad_q[2*N-3:0], 2'b00};
      rem_q  <= rem_nxt[N:0];
      root_q <= {root_q[N-2:0], ge};
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o   = busy_q && (cnt_q == CW'(1));
  assign root_o   = root_q;
  assign sticky_o = |rem_q;

endmodule

// File: rtl/fp_sqrt_pipe.sv
// IEEE-754 square root, parametrised widths, correctly rounded, with flags.
// Latency FRAC_W+3 cycles for normal operands, 1 cycle for special operands.
// Backpressure: result held in DONE until o_ready; i_ready low outside IDLE.
// Ports: clk, reset_n (async active-low); i_valid/i_ready + i_sign/i_exp/i_frac
//   operand; o_valid/o_ready + o_sign/o_exp/o_frac result, o_invalid, o_inexact.
// Build option: define FP_SQRT_RNE_EN for round-to-nearest-even, otherwise the
//   result is truncated (round toward zero); latency is the same either way.
module fp_sqrt_pipe
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_invalid,
  output logic              o_inexact
);

  localparam int N = FRAC_W + 2;
  localparam logic [EXP_W:0]          BIAS      = (EXP_W + 1)'(bias(EXP_W));
  localparam logic [QNAN_MAX_W-1:0]   QNAN_V    = qnan(EXP_W, FRAC_W);
  localparam logic [EXP_W-1:0]        QNAN_EXP  = QNAN_V[FRAC_W +: EXP_W];
  localparam logic [FRAC_W-1:0]       QNAN_FRAC = QNAN_V[FRAC_W-1:0];

  state_e            state_q;
  logic              i_ready_q;
  logic              o_valid_q;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [FRAC_W-1:0] frac_q;
  logic              invalid_q;
  logic              inexact_q;

  // ---------------- operand classification and radicand setup -------------
  logic            exp_ones, exp_zero, frac_zero, accept;
  cls_e            cls;
  logic [EXP_W:0]  exp_sum;
  logic [FRAC_W:0] mant;
  logic [2*N-1:0]  rad;
  logic            core_start;

  assign exp_ones  = &i_exp;
  assign exp_zero  = ~|i_exp;
  assign frac_zero = ~|i_frac;
  assign accept    = i_valid && i_ready_q;

  // A negative operand only counts as "negative nonzero" when its exponent is
  // nonzero; negative subnormals are flushed to -0 like negative zero.
  always_comb begin
    cls = NORM;
    if (exp_ones && !frac_zero) begin
      cls = NAN;
    end else if (i_sign && !exp_zero) begin
      cls = NEG;
    end else if (exp_zero) begin
      cls = ZERO;
    end else if (exp_ones) begin
      cls = INF;
    end
  end

  // floor((E-B)/2)+B equals (E+B)>>1, and E-B is odd exactly when E+B is odd,
  // so one adder gives both the result exponent and the radicand alignment.
  assign exp_sum = {1'b0, i_exp} + BIAS;
  assign mant    = {1'b1, i_frac};
  assign rad     = exp_sum[0] ? {mant, {(FRAC_W + 3){1'b0}}}
                              : {1'b0, mant, {(FRAC_W + 2){1'b0}}};

  assign core_start = (state_q == IDLE) && accept && (cls == NORM);

  // ---------------- recurrence datapath ------------------------------------
  logic         core_done;
  logic [N-1:0] root;
  logic         sticky;

  fp_sqrt_core #(.N(N)) u_core (
    .clk      (clk),
    .rst_ni   (reset_n),
    .start_i  (core_start),
    .rad_i    (rad),
    .done_o   (core_done),
    .root_o   (root),
    .sticky_o (sticky)
  );

  // ---------------- rounding -----------------------------------------------
  // root = {integer bit, FRAC_W fraction bits, guard bit}
  logic              guard, inc, carry;
  logic [FRAC_W+1:0] rnd_sum;

  assign guard = root[0];

  always_comb begin
`ifdef FP_SQRT_RNE_EN
    inc = guard && (sticky || root[1]);
`else
    inc = 1'b0;
`endif
  end

  // The hidden bit is always set, so the top two sum bits are 01 normally and
  // 10 only when the increment carries out of the mantissa (fraction then 0).
  assign rnd_sum = {1'b0, root[N-1:1]} + (FRAC_W + 2)'(inc);
  assign carry   = (rnd_sum[FRAC_W+1:FRAC_W] == 2'b10);

  // ---------------- controller ---------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      i_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          i_ready_q <= 1'b1;
          if (accept) begin
            i_ready_q <= 1'b0;
            sign_q    <= 1'b0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
            case (cls)
              NAN: begin
                exp_q   <= QNAN_EXP;
                frac_q  <= QNAN_FRAC;
                state_q <= DONE;
              end
              NEG: begin
                exp_q     <= QNAN_EXP;
                frac_q    <= QNAN_FRAC;
                invalid_q <= 1'b1;
                state_q   <= DONE;
              end
              ZERO: begin
                sign_q  <= i_sign;
                exp_q   <= '0;
                frac_q  <= '0;
                state_q <= DONE;
              end
              INF: begin
                exp_q   <= '1;
                frac_q  <= '0;
                state_q <= DONE;
              end
              default: begin
                exp_q   <= exp_sum[EXP_W:1];
                state_q <= CALC;
              end
            endcase
          end
        end
        CALC: begin
          if (core_done) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          frac_q    <= rnd_sum[FRAC_W-1:0];
          exp_q     <= exp_q + EXP_W'(carry);
          inexact_q <= guard | sticky;
          o_valid_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          // Special results enter DONE straight from IDLE with o_valid still
          // low; it rises on the following edge, a fixed one-cycle latency.
          if (!o_valid_q) begin
            o_valid_q <= 1'b1;
          end else if (o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ready   = i_ready_q;
  assign o_valid   = o_valid_q;
  assign o_sign    = sign_q;
  assign o_exp     = exp_q;
  assign o_frac    = frac_q;
  assign o_invalid = invalid_q;
  assign o_inexact = inexact_q;

endmodule
